// File: rtl/apb_slave_responder_pkg.sv
// apb_slave_responder_pkg: shared widths, transfer enums and responder FSM states
package apb_slave_responder_pkg;
  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int SLAVE_MEMORY_DEPTH = 16;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} tx_type_e;
  typedef enum logic {NO_ERROR = 1'b0, ERROR = 1'b1} slave_error_e;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_responder_state_e;
endpackage

// File: rtl/apb_responder_mem.sv
// apb_responder_mem: register file with async clear, byte-enable write port and one read port
module apb_responder_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 16
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] widx,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      strb,
  input  logic [$clog2(MEM_DEPTH)-1:0] ridx,
  output logic [DATA_WIDTH-1:0]        rdata
);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  // clear every word on reset, otherwise update only the enabled byte lanes
  always_ff @(posedge pclk or posedge preset)
    if (preset) for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    else if (we) for (int b = 0; b < DATA_WIDTH/8; b++) if (strb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
  assign rdata = mem[ridx];
endmodule

// File: rtl/apb_slave_responder.sv
// apb_slave_responder: APB completer with one decoded window, wait states and error response
module apb_slave_responder #(
  parameter int          ADDRESS_WIDTH = apb_slave_responder_pkg::ADDRESS_WIDTH,
  parameter int          DATA_WIDTH = apb_slave_responder_pkg::DATA_WIDTH,
  parameter int          MEM_DEPTH = apb_slave_responder_pkg::SLAVE_MEMORY_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  input  logic [3:0]                cfg_wait_states,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);
  import apb_slave_responder_pkg::*;
  localparam int BYTES = DATA_WIDTH/8;
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int BW = $clog2(BYTES);
  localparam int WINDOW = MEM_DEPTH*BYTES;
  apb_responder_state_e state, state_n;
  tx_type_e type_q;
  slave_error_e err_in, err_q;
  logic [ADDRESS_WIDTH:0] off;
  logic [IW-1:0] idx_in, idx_q, rd_idx;
  logic [DATA_WIDTH-1:0] wdata_q, rd_data, prdata_n;
  logic [BYTES-1:0] strb_q;
  logic [3:0] cnt, cnt_n;
  logic pready_n, pslverr_n, load, we, unused_prot;
  assign unused_prot = pprot[0] ^ pprot[2];
  assign off = {1'b0, paddr} - (ADDRESS_WIDTH+1)'(BASE_ADDR);
  assign err_in = (off[ADDRESS_WIDTH] || off >= (ADDRESS_WIDTH+1)'(WINDOW) ||
                   (|(paddr & ADDRESS_WIDTH'(BYTES-1))) ||
                   (pprot[1] && off >= (ADDRESS_WIDTH+1)'(WINDOW/2))) ? ERROR : NO_ERROR;
  assign idx_in = IW'(off >> BW);
  assign rd_idx = state == IDLE ? idx_in : idx_q;
  assign we = state == ACCESS && pready && psel && type_q == WRITE && err_q == NO_ERROR;
  // next state, wait counter and the registered response for the coming cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    load = 1'b0;
    pready_n = 1'b0;
    pslverr_n = 1'b0;
    prdata_n = '0;
    if (state == IDLE) begin
      if (psel && !penable) begin
        state_n = ACCESS;
        cnt_n = cfg_wait_states;
        load = 1'b1;
        pready_n = cfg_wait_states == 4'd0;
        pslverr_n = pready_n && err_in == ERROR;
        prdata_n = (pready_n && !pwrite && err_in == NO_ERROR) ? rd_data : '0;
      end
    end else if (!psel || pready) begin
      state_n = IDLE;
      cnt_n = '0;
    end else begin
      cnt_n = cnt - 4'd1;
      pready_n = cnt == 4'd1;
      pslverr_n = pready_n && err_q == ERROR;
      prdata_n = (pready_n && type_q == READ && err_q == NO_ERROR) ? rd_data : '0;
    end
  end
  // FSM state, counter and response outputs
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state <= IDLE;
      cnt <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pready <= pready_n;
      pslverr <= pslverr_n;
      prdata <= prdata_n;
    end
  // transfer controls captured in the setup cycle and held through the access phase
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      type_q <= READ;
      err_q <= NO_ERROR;
      idx_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
    end else if (load) begin
      type_q <= pwrite ? WRITE : READ;
      err_q <= err_in;
      idx_q <= idx_in;
      wdata_q <= pwdata;
      strb_q <= pstrb;
    end
  apb_responder_mem #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_mem (
    .pclk(pclk),
    .preset(preset),
    .we(we),
    .widx(idx_q),
    .wdata(wdata_q),
    .strb(strb_q),
    .ridx(rd_idx),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_apb_slave_responder.sv
// tb_apb_slave_responder: directed and random APB transfers checked against a word-array model
module tb_apb_slave_responder;
  localparam logic [31:0] B = 32'h0000_1000;
  logic pclk = 1'b0, preset = 1'b1, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, prdata;
  logic [3:0] pstrb = '0, cfg_wait_states = '0;
  logic [2:0] pprot = '0;
  logic pready, pslverr;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mem_m [16];

  always #5 pclk = ~pclk;

  apb_slave_responder #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .BASE_ADDR(B)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .cfg_wait_states(cfg_wait_states), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] pr);
    return a < B || a >= B + 32'd64 || a[1:0] != 2'b00 || (pr[1] && a >= B + 32'd32);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return B + 32'($urandom_range(0, 63));
    if (r == 2) return B - 32'd4;
    return B + 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
  endtask

  task automatic hold_reset();
    preset = 1'b1;
    psel = 1'b0;
    penable = 1'b0;
    repeat (2) @(posedge pclk);
    #2 preset = 1'b0;
    clear_model();
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic [2:0] pr, input int ws, input bit gap, output logic [31:0] rd);
    int n, k;
    bit e;
    @(posedge pclk); #1;
    if (gap) begin
      psel = 1'b0;
      penable = 1'b0;
      @(posedge pclk); #1;
    end
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
    cfg_wait_states = 4'(ws);
    check("setup_pready", {31'b0, pready}, 0);
    n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
      if (n == 1) begin
        penable = 1'b1;
        pwrite = 1'($urandom); paddr = $urandom; pwdata = $urandom;
        pstrb = 4'($urandom); pprot = 3'($urandom); cfg_wait_states = 4'($urandom);
      end
      if (!pready) check("wait_outputs", prdata | {31'b0, pslverr}, 0);
    end while (!pready && n < 40);
    check("latency", n, ws + 1);
    e = model_err(a, pr);
    k = int'((a - B) >> 2) & 15;
    if (wr && !e) for (int b = 0; b < 4; b++) if (st[b]) mem_m[k][b*8 +: 8] = wd[b*8 +: 8];
    check("pslverr", {31'b0, pslverr}, {31'b0, e});
    if (!wr) check("prdata", prdata, e ? 32'h0 : mem_m[k]);
    rd = prdata;
  endtask

  initial begin
    logic [31:0] rd;
    clear_model();
    repeat (2) @(posedge pclk);
    #1;
    check("rst_pready", {31'b0, pready}, 0);
    check("rst_pslverr", {31'b0, pslverr}, 0);
    check("rst_prdata", prdata, 0);
    #1 preset = 1'b0;

    xfer(1, B + 4, 32'hDEADBEEF, 4'hF, 3'b000, 0, 1, rd);
    xfer(0, B + 4, 32'h0, 4'hF, 3'b000, 0, 0, rd);
    check("zero_wait_read", rd, 32'hDEADBEEF);
    xfer(0, B, 32'h0, 4'h0, 3'b000, 3, 1, rd);
    check("wait3_read", rd, 32'h0);

    xfer(1, B + 8, 32'h11223344, 4'hF, 3'b000, 1, 0, rd);
    xfer(1, B + 8, 32'hAABBCCDD, 4'b0010, 3'b000, 2, 0, rd);
    xfer(0, B + 8, 32'h0, 4'h0, 3'b000, 0, 1, rd);
    check("strb_merge", rd, 32'h1122CC44);

    xfer(0, B + 64, 32'h0, 4'h0, 3'b000, 0, 0, rd);
    xfer(1, B + 2, 32'hFFFFFFFF, 4'hF, 3'b000, 1, 0, rd);
    xfer(1, B + 40, 32'h12345678, 4'hF, 3'b010, 0, 0, rd);
    xfer(0, B + 40, 32'h0, 4'h0, 3'b000, 0, 0, rd);
    xfer(0, B - 4, 32'h0, 4'h0, 3'b000, 2, 1, rd);
    xfer(1, B + 8, 32'h99999999, 4'h0, 3'b000, 0, 0, rd);
    xfer(1, B + 12, 32'h0F0F0F0F, 4'hF, 3'b010, 0, 0, rd);
    xfer(0, B + 12, 32'h0, 4'h0, 3'b010, 1, 0, rd);

    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = B + 8; pwdata = 32'hCAFEF00D;
    pstrb = 4'hF; pprot = 3'b000; cfg_wait_states = 4'd4;
    @(posedge pclk); #1;
    penable = 1'b1;
    check("abort_wait1", {31'b0, pready}, 0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    check("abort_wait2", {31'b0, pready}, 0);
    @(posedge pclk); #1;
    check("abort_idle", {31'b0, pready}, 0);
    xfer(0, B + 8, 32'h0, 4'h0, 3'b000, 0, 1, rd);
    check("abort_keeps_old", rd, 32'h1122CC44);

    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = B + 8; cfg_wait_states = 4'd0;
    repeat (3) begin
      @(posedge pclk); #1;
      check("no_setup_pready", {31'b0, pready}, 0);
    end
    xfer(0, B + 8, 32'h0, 4'h0, 3'b000, 0, 0, rd);

    repeat (200)
      xfer(1'($urandom), rand_addr(), $urandom, 4'($urandom), 3'($urandom),
           $urandom_range(0, 3), $urandom_range(0, 2) == 0, rd);

    xfer(1, B + 12, 32'h5A5AA5A5, 4'hF, 3'b000, 0, 0, rd);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = B + 12; pprot = 3'b000; cfg_wait_states = 4'd0;
    @(posedge pclk); #1;
    penable = 1'b1;
    check("pre_rst_pready", {31'b0, pready}, 1);
    check("pre_rst_prdata", prdata, 32'h5A5AA5A5);
    #2 preset = 1'b1;
    #1;
    check("rst_now_pready", {31'b0, pready}, 0);
    check("rst_now_prdata", prdata, 0);
    hold_reset();

    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = B + 16; pwdata = 32'hFFFFFFFF;
    pstrb = 4'hF; pprot = 3'b000; cfg_wait_states = 4'd3;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 preset = 1'b1;
    #1;
    check("rst_wr_pready", {31'b0, pready}, 0);
    hold_reset();

    for (int i = 0; i < 16; i++) xfer(0, B + 32'(4 * i), 32'h0, 4'h0, 3'b000, i % 2, i % 3 == 0, rd);
    xfer(1, B + 20, 32'h0BADCAFE, 4'hF, 3'b000, 0, 0, rd);
    xfer(0, B + 20, 32'h0, 4'h0, 3'b000, 0, 0, rd);
    check("b2b_read", rd, 32'h0BADCAFE);

    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
